// File: rtl/psram_seq_pkg.sv
// psram_seq_pkg: shared states, grant encoding and fixed AXI field values for the PSRAM sequencer
package psram_seq_pkg;
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA} state_t;
  typedef enum logic {WRITE, READ} grant_t;
  localparam int ID_W = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] PROT_DEFAULT = 3'b001;
endpackage

// File: rtl/psram_rr_arb2.sv
// psram_rr_arb2: two-requester round-robin arbiter; a tie goes to the side not granted last
module psram_rr_arb2
  import psram_seq_pkg::*;
(
  input  logic clk,
  input  logic aresetn,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic gnt_wr,
  output logic gnt_rd
);
  grant_t last_grant;
  assign gnt_wr = en && wr_req && (!rd_req || last_grant == READ);
  assign gnt_rd = en && rd_req && (!wr_req || last_grant == WRITE);
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) last_grant <= READ;
    else if (gnt_wr) last_grant <= WRITE;
    else if (gnt_rd) last_grant <= READ;
  end
endmodule

// File: rtl/psram_axi_sequencer.sv
// psram_axi_sequencer: single-beat AXI4 master sharing the PSRAM slave between record writes and playback reads
module psram_axi_sequencer
  import psram_seq_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_done,
  output logic                wr_err,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_done,
  output logic                rd_err,
  output logic                busy,
  output logic                timeout_flag,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic [3:0]          m_axi_awregion,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic [3:0]          m_axi_arregion,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic gnt_wr, gnt_rd, wr_ev, rd_ev, to_hit, aw_q, w_q, ar_q, unused_ids;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [CNT_W-1:0] cnt;
  psram_rr_arb2 u_arb (
    .clk    (clk),
    .aresetn(aresetn),
    .en     (state == IDLE),
    .wr_req (wr_req_valid),
    .rd_req (rd_req_valid),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );
  assign wr_req_ready = gnt_wr;
  assign rd_req_ready = gnt_rd;
  assign busy = state != IDLE;
  assign to_hit = cnt == CNT_W'(TIMEOUT - 1);
  assign wr_ev = state == WR_RESP && (m_axi_bvalid || to_hit);
  assign rd_ev = state == RD_DATA && (m_axi_rvalid || to_hit);
  assign m_axi_bready = state == WR_RESP;
  assign m_axi_rready = state == RD_DATA;
  assign m_axi_awid = '0;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = 8'd0;
  assign m_axi_awsize = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_awqos = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awvalid = aw_q;
  assign m_axi_wdata = wdata_q;
  assign m_axi_wstrb = strb_q;
  assign m_axi_wlast = w_q;
  assign m_axi_wvalid = w_q;
  assign m_axi_arid = '0;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = 8'd0;
  assign m_axi_arsize = SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot = PROT_DEFAULT;
  assign m_axi_arqos = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arvalid = ar_q;
  // only one ID is ever issued, so response IDs carry no information
  assign unused_ids = ^{m_axi_bid, m_axi_rid};
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = gnt_wr ? WR_AW_W : gnt_rd ? RD_AR : IDLE;
      WR_AW_W: state_n = ((!aw_q || m_axi_awready) && (!w_q || m_axi_wready)) ? WR_RESP : WR_AW_W;
      WR_RESP: state_n = wr_ev ? IDLE : WR_RESP;
      RD_AR:   state_n = m_axi_arready ? RD_DATA : RD_AR;
      RD_DATA: state_n = rd_ev ? IDLE : RD_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      aw_q <= 1'b0;
      w_q <= 1'b0;
      ar_q <= 1'b0;
      cnt <= '0;
      wr_done <= 1'b0;
      wr_err <= 1'b0;
      rd_done <= 1'b0;
      rd_err <= 1'b0;
      rd_data <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (gnt_wr) begin
        addr_q <= wr_addr;
        wdata_q <= wr_data;
        strb_q <= wr_strb;
      end else if (gnt_rd) addr_q <= rd_addr;
      // each VALID falls independently after its own handshake
      aw_q <= gnt_wr || (aw_q && !m_axi_awready);
      w_q <= gnt_wr || (w_q && !m_axi_wready);
      ar_q <= gnt_rd || (ar_q && !m_axi_arready);
      cnt <= (state == WR_RESP || state == RD_DATA) ? cnt + 1'b1 : '0;
      wr_done <= wr_ev;
      wr_err <= wr_ev && (!m_axi_bvalid || m_axi_bresp != RESP_OKAY);
      rd_done <= rd_ev;
      rd_err <= rd_ev && (!m_axi_rvalid || m_axi_rresp != RESP_OKAY || !m_axi_rlast);
      if (rd_ev && m_axi_rvalid) rd_data <= m_axi_rdata;
      timeout_flag <= timeout_flag || (wr_ev && !m_axi_bvalid) || (rd_ev && !m_axi_rvalid);
    end
  end
endmodule
